// File: rtl/vid_timing_decoder.sv
// Video timing decoder: turns received h_sync/v_sync/de into active-area
// coordinates, measures line width and frame height, and tracks lock to the
// expected resolution through a SEARCH -> CHECK -> LOCKED state machine.
// Every output is registered directly from the single input sample stage.
module vid_timing_decoder #(
    parameter int   H_RES_PIX   = 640,
    parameter int   V_RES_PIX   = 480,
    parameter logic H_SYNC_POL  = 1'b0,
    parameter logic V_SYNC_POL  = 1'b0,
    parameter int   LOCK_FRAMES = 2
) (
    input  logic        p_clk_x1,
    input  logic        reset_n,
    input  logic        h_sync,
    input  logic        v_sync,
    input  logic        de,
    input  logic [23:0] pixel_in,
    output logic [10:0] hpos,
    output logic [10:0] vpos,
    output logic [23:0] pixel_out,
    output logic        active,
    output logic        line_start,
    output logic        frame_start,
    output logic        locked,
    output logic        timing_err,
    output logic [10:0] meas_h,
    output logic [10:0] meas_v
);

    typedef enum logic [1:0] {
        ST_SEARCH = 2'd0,
        ST_CHECK  = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    localparam logic [10:0] HPOS_MAX = 11'd2047;

    state_t      state_r, state_nxt_s;
    logic [3:0]  good_cnt_r, good_cnt_nxt_s;
    logic        frame_bad_r, frame_bad_nxt_s;
    logic        err_nxt_s;

    logic        de_prev_r, vs_prev_r, hs_prev_r;
    logic        vs_pend_r;
    logic [10:0] line_cnt_r, line_cnt_nxt_s;
    logic [10:0] hs_cnt_r;

    logic        vs_act_s, hs_act_s;
    logic        de_rise_s, de_fall_s, vs_edge_s, hs_edge_s;
    logic [10:0] h_count_s;
    logic        h_bad_s, v_bad_s;
    logic [4:0]  good_inc_s;

    // Sync levels normalised to "asserted" and edges taken against the previous sample.
    assign vs_act_s  = (v_sync == V_SYNC_POL);
    assign hs_act_s  = (h_sync == H_SYNC_POL);
    assign de_rise_s = de & ~de_prev_r;
    assign de_fall_s = ~de & de_prev_r;
    assign vs_edge_s = vs_act_s & ~vs_prev_r;
    assign hs_edge_s = hs_act_s & ~hs_prev_r;

    // Pixels in the line that just ended: last hpos + 1, held at the 11-bit ceiling.
    assign h_count_s  = (hpos == HPOS_MAX) ? HPOS_MAX : (hpos + 11'd1);
    assign h_bad_s    = de_fall_s && (h_count_s != 11'(H_RES_PIX));
    assign v_bad_s    = vs_edge_s && (line_cnt_r != 11'(V_RES_PIX));
    assign good_inc_s = {1'b0, good_cnt_r} + 5'd1;

    // Line counter: a v_sync edge clears it with priority over a de fall.
    always_comb begin
        line_cnt_nxt_s = line_cnt_r;
        if (vs_edge_s) begin
            line_cnt_nxt_s = 11'd0;
        end else if (de_fall_s) begin
            line_cnt_nxt_s = line_cnt_r + 11'd1;
        end else begin
            line_cnt_nxt_s = line_cnt_r;
        end
    end

    // Lock FSM next state, good-frame counter, frame-bad flag and error pulse.
    always_comb begin
        state_nxt_s     = state_r;
        good_cnt_nxt_s  = good_cnt_r;
        frame_bad_nxt_s = frame_bad_r;
        err_nxt_s       = 1'b0;
        case (state_r)
            ST_SEARCH: begin
                if (vs_edge_s) begin
                    state_nxt_s     = ST_CHECK;
                    good_cnt_nxt_s  = 4'd0;
                    frame_bad_nxt_s = 1'b0;
                end else begin
                    state_nxt_s = ST_SEARCH;
                end
            end
            ST_CHECK: begin
                if (vs_edge_s) begin
                    frame_bad_nxt_s = 1'b0;
                    if (!frame_bad_r && !h_bad_s && !v_bad_s) begin
                        if (good_inc_s >= 5'(LOCK_FRAMES)) begin
                            state_nxt_s    = ST_LOCKED;
                            good_cnt_nxt_s = 4'd0;
                        end else begin
                            good_cnt_nxt_s = good_inc_s[3:0];
                        end
                    end else begin
                        good_cnt_nxt_s = 4'd0;
                    end
                end else if (h_bad_s) begin
                    frame_bad_nxt_s = 1'b1;
                end else begin
                    frame_bad_nxt_s = frame_bad_r;
                end
            end
            ST_LOCKED: begin
                if (h_bad_s || v_bad_s) begin
                    err_nxt_s   = 1'b1;
                    state_nxt_s = ST_SEARCH;
                end else begin
                    state_nxt_s = ST_LOCKED;
                end
            end
            default: begin
                state_nxt_s     = ST_SEARCH;
                good_cnt_nxt_s  = 4'd0;
                frame_bad_nxt_s = 1'b0;
            end
        endcase
    end

    // Lock FSM state register with the lock/error outputs registered alongside.
    always_ff @(posedge p_clk_x1 or negedge reset_n) begin
        if (!reset_n) begin
            state_r     <= ST_SEARCH;
            good_cnt_r  <= 4'd0;
            frame_bad_r <= 1'b0;
            locked      <= 1'b0;
            timing_err  <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            good_cnt_r  <= good_cnt_nxt_s;
            frame_bad_r <= frame_bad_nxt_s;
            locked      <= (state_nxt_s == ST_LOCKED);
            timing_err  <= err_nxt_s;
        end
    end

    // Edge history, coordinates, measurements and pass-through pixel path.
    always_ff @(posedge p_clk_x1 or negedge reset_n) begin
        if (!reset_n) begin
            de_prev_r   <= 1'b0;
            vs_prev_r   <= 1'b0;
            hs_prev_r   <= 1'b0;
            vs_pend_r   <= 1'b0;
            line_cnt_r  <= 11'd0;
            hs_cnt_r    <= 11'd0;
            hpos        <= 11'd0;
            vpos        <= 11'd0;
            pixel_out   <= 24'd0;
            active      <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            meas_h      <= 11'd0;
            meas_v      <= 11'd0;
        end else begin
            de_prev_r   <= de;
            vs_prev_r   <= vs_act_s;
            hs_prev_r   <= hs_act_s;
            pixel_out   <= pixel_in;
            active      <= de;
            line_start  <= de_rise_s;
            frame_start <= de_rise_s && (vs_pend_r || vs_edge_s);
            line_cnt_r  <= line_cnt_nxt_s;
            vpos        <= line_cnt_nxt_s;
            // frame_start is owed from a v_sync edge until the next de rise
            if (de_rise_s) begin
                vs_pend_r <= 1'b0;
            end else if (vs_edge_s) begin
                vs_pend_r <= 1'b1;
            end else begin
                vs_pend_r <= vs_pend_r;
            end
            // h_sync pulses per frame, kept as a line-count sanity reference
            if (vs_edge_s) begin
                hs_cnt_r <= 11'd0;
            end else if (hs_edge_s && (hs_cnt_r != HPOS_MAX)) begin
                hs_cnt_r <= hs_cnt_r + 11'd1;
            end else begin
                hs_cnt_r <= hs_cnt_r;
            end
            if (de_rise_s) begin
                hpos <= 11'd0;
            end else if (de && (hpos != HPOS_MAX)) begin
                hpos <= hpos + 11'd1;
            end else begin
                hpos <= hpos;
            end
            if (de_fall_s) begin
                meas_h <= h_count_s;
            end else begin
                meas_h <= meas_h;
            end
            if (vs_edge_s) begin
                meas_v <= line_cnt_r;
            end else begin
                meas_v <= meas_v;
            end
        end
    end

endmodule

// File: tb/tb_vid_timing_decoder.sv
// Directed bench for vid_timing_decoder, run at a reduced 8x4 resolution so
// that many frames fit in a short run. Inputs change 1 ns after a rising
// edge and outputs are sampled there, i.e. they describe the sample just taken.
module tb_vid_timing_decoder;

    localparam int HR = 8;
    localparam int VR = 4;

    logic        p_clk_x1 = 1'b0;
    logic        reset_n  = 1'b0;
    logic        h_sync   = 1'b1;
    logic        v_sync   = 1'b1;
    logic        de       = 1'b0;
    logic [23:0] pixel_in = 24'd0;
    logic [10:0] hpos, vpos, meas_h, meas_v;
    logic [23:0] pixel_out;
    logic        active, line_start, frame_start, locked, timing_err;

    int n_checks = 0;
    int n_errors = 0;

    vid_timing_decoder #(
        .H_RES_PIX  (HR),
        .V_RES_PIX  (VR),
        .H_SYNC_POL (1'b0),
        .V_SYNC_POL (1'b0),
        .LOCK_FRAMES(2)
    ) dut (
        .p_clk_x1   (p_clk_x1),
        .reset_n    (reset_n),
        .h_sync     (h_sync),
        .v_sync     (v_sync),
        .de         (de),
        .pixel_in   (pixel_in),
        .hpos       (hpos),
        .vpos       (vpos),
        .pixel_out  (pixel_out),
        .active     (active),
        .line_start (line_start),
        .frame_start(frame_start),
        .locked     (locked),
        .timing_err (timing_err),
        .meas_h     (meas_h),
        .meas_v     (meas_v)
    );

    always #5 p_clk_x1 = ~p_clk_x1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge p_clk_x1);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_hpos"},  32'(hpos),        32'd0);
        chk({tag, "_vpos"},  32'(vpos),        32'd0);
        chk({tag, "_pix"},   32'(pixel_out),   32'd0);
        chk({tag, "_act"},   32'(active),      32'd0);
        chk({tag, "_ls"},    32'(line_start),  32'd0);
        chk({tag, "_fs"},    32'(frame_start), 32'd0);
        chk({tag, "_lock"},  32'(locked),      32'd0);
        chk({tag, "_err"},   32'(timing_err),  32'd0);
        chk({tag, "_mh"},    32'(meas_h),      32'd0);
        chk({tag, "_mv"},    32'(meas_v),      32'd0);
    endtask

    // One line of n de cycles plus blanking with an h_sync pulse.
    task automatic do_line(input int n, input int exp_v, input logic exp_fs,
                           input logic exp_err, input logic exp_lock);
        logic [23:0] pix;
        for (int i = 0; i < n; i++) begin
            pix      = 24'($urandom);
            pixel_in = pix;
            de       = 1'b1;
            step();
            chk("hpos", 32'(hpos), (i < 2047) ? 32'(i) : 32'd2047);
            chk("vpos", 32'(vpos), 32'(exp_v));
            chk("pixel_out", 32'(pixel_out), 32'(pix));
            chk("active", 32'(active), 32'd1);
            chk("line_start", 32'(line_start), (i == 0) ? 32'd1 : 32'd0);
            chk("frame_start", 32'(frame_start), (i == 0) ? 32'(exp_fs) : 32'd0);
        end
        de = 1'b0;
        step();
        chk("active_fall", 32'(active), 32'd0);
        chk("meas_h", 32'(meas_h), (n > 2047) ? 32'd2047 : 32'(n));
        chk("err_at_fall", 32'(timing_err), 32'(exp_err));
        chk("lock_at_fall", 32'(locked), 32'(exp_lock));
        h_sync = 1'b0;
        step();
        chk("err_pulse_end", 32'(timing_err), 32'd0);
        h_sync = 1'b1;
        step();
        step();
    endtask

    // v_sync pulse with the de-low porch; checks taken one cycle after the edge.
    task automatic do_vsync(input int exp_mv, input logic exp_lock, input logic exp_err);
        v_sync = 1'b0;
        step();
        chk("meas_v", 32'(meas_v), 32'(exp_mv));
        chk("lock_at_vs", 32'(locked), 32'(exp_lock));
        chk("err_at_vs", 32'(timing_err), 32'(exp_err));
        step();
        chk("err_vs_end", 32'(timing_err), 32'd0);
        v_sync = 1'b1;
        step();
        step();
    endtask

    task automatic do_frame(input int nl, input int exp_mv, input logic lock_vs,
                            input logic err_vs, input logic lock_lines);
        do_vsync(exp_mv, lock_vs, err_vs);
        for (int l = 0; l < nl; l++) begin
            do_line(HR, l, (l == 0), 1'b0, lock_lines);
        end
    endtask

    initial begin
        logic [23:0] pix;
        // reset state
        repeat (3) @(posedge p_clk_x1);
        #1;
        chk_all_zero("reset");
        #2 reset_n = 1'b1;
        step();
        chk_all_zero("post_reset_idle");

        // saturating line in SEARCH, no v_sync seen yet: no frame_start, no error
        do_line(2050, 0, 1'b0, 1'b0, 1'b0);

        // three clean frames -> lock one cycle after the third v_sync edge
        do_frame(VR, 1,  1'b0, 1'b0, 1'b0);
        do_frame(VR, VR, 1'b0, 1'b0, 1'b0);
        do_frame(VR, VR, 1'b1, 1'b0, 1'b1);

        // locked, short line -> error pulse and unlock at the de fall
        do_vsync(VR, 1'b1, 1'b0);
        do_line(HR,     0, 1'b1, 1'b0, 1'b1);
        do_line(HR - 1, 1, 1'b0, 1'b1, 1'b0);
        do_line(HR,     2, 1'b0, 1'b0, 1'b0);
        do_line(HR,     3, 1'b0, 1'b0, 1'b0);
        // relock after two further clean frames
        do_frame(VR, VR, 1'b0, 1'b0, 1'b0);
        do_frame(VR, VR, 1'b0, 1'b0, 1'b0);
        do_frame(VR - 1, VR, 1'b1, 1'b0, 1'b1);

        // locked, short frame -> error at the v_sync edge
        do_frame(VR, VR - 1, 1'b0, 1'b1, 1'b0);
        do_frame(VR, VR, 1'b0, 1'b0, 1'b0);
        // CHECK with good count 1, short frame -> count clears silently
        do_frame(VR - 1, VR, 1'b0, 1'b0, 1'b0);
        do_frame(VR, VR - 1, 1'b0, 1'b0, 1'b0);
        do_frame(VR, VR, 1'b0, 1'b0, 1'b0);
        do_frame(VR, VR, 1'b1, 1'b0, 1'b1);

        // de rise on the same cycle as the v_sync edge
        pix      = 24'($urandom);
        pixel_in = pix;
        v_sync   = 1'b0;
        de       = 1'b1;
        step();
        chk("co_vpos", 32'(vpos), 32'd0);
        chk("co_hpos", 32'(hpos), 32'd0);
        chk("co_ls", 32'(line_start), 32'd1);
        chk("co_fs", 32'(frame_start), 32'd1);
        chk("co_mv", 32'(meas_v), 32'(VR));
        chk("co_pix", 32'(pixel_out), 32'(pix));
        v_sync = 1'b1;
        for (int i = 1; i < HR; i++) begin
            step();
            chk("co_hpos_run", 32'(hpos), 32'(i));
            chk("co_fs_run", 32'(frame_start), 32'd0);
        end
        de = 1'b0;
        step();
        chk("co_meas_h", 32'(meas_h), 32'(HR));
        chk("co_lock", 32'(locked), 32'd1);
        step();
        step();
        for (int l = 1; l < VR; l++) begin
            do_line(HR, l, 1'b0, 1'b0, 1'b1);
        end

        // asynchronous reset mid-line while locked
        de = 1'b1;
        step();
        step();
        step();
        #3 reset_n = 1'b0;
        #1;
        chk_all_zero("async_reset");
        de = 1'b0;
        repeat (2) @(posedge p_clk_x1);
        #2 reset_n = 1'b1;
        do_line(HR, 0, 1'b0, 1'b0, 1'b0);
        do_vsync(1, 1'b0, 1'b0);
        do_line(HR, 0, 1'b1, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
